// File: rtl/store_buffer.sv
// Store buffer between MEM stage and data-memory write port: circular FIFO of byte-masked word stores.
// Latency: a pushed store is visible to drain and load lookup from the cycle after it is accepted; drain is one store per granted cycle.
// Backpressure: st_ready = !full from registered state only; a full buffer refuses a push even when the head drains that cycle.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   st_valid/st_ready           store handshake; st_addr/st_be/st_data carry the store (st_be == 0 is accepted and dropped)
//   dm_grant                    data-memory write port is free this cycle
//   dm_wr/dm_addr/dm_be/dm_din  data-memory write drive from the head entry
//   ld_addr                     load address for the forwarding / hazard lookup
//   ld_fwd_be/ld_fwd_data       lanes and data supplied by the buffer to a load
//   ld_stall                    load must wait for the buffer to drain a matching store
//   full/empty/count            occupancy status
//
// Build option: define SB_FWD_EN for store-to-load forwarding; without it a matching load stalls instead.

module store_buffer #(
    parameter int DEPTH = 4,   // entries, power of two in 2..16
    parameter int CW    = 3    // occupancy counter width, log2(DEPTH)+1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [31:0]   st_addr,
    input  logic [3:0]    st_be,
    input  logic [31:0]   st_data,
    input  logic          dm_grant,
    output logic          dm_wr,
    output logic [31:0]   dm_addr,
    output logic [3:0]    dm_be,
    output logic [31:0]   dm_din,
    input  logic [31:0]   ld_addr,
    output logic [3:0]    ld_fwd_be,
    output logic [31:0]   ld_fwd_data,
    output logic          ld_stall,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry storage; payloads are not reset, only the pointers and count.
    logic [29:0]   r_addr [DEPTH];
    logic [3:0]    r_be   [DEPTH];
    logic [31:0]   r_data [DEPTH];

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_unused_lsbs;

    // Byte offsets inside the word are irrelevant: entries are word-granular.
    assign w_unused_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

    //------------------------------------------------------------------
    // Status and handshake
    //------------------------------------------------------------------
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);

    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign st_ready = !w_full;

    // A store with no byte enables completes the handshake but writes nothing.
    assign w_push   = st_valid && !w_full && (st_be != 4'b0000);

    //------------------------------------------------------------------
    // Drain: the head goes out whenever the write port is granted
    //------------------------------------------------------------------
    assign w_pop    = !w_empty && dm_grant;
    assign dm_wr    = w_pop;
    assign dm_addr  = {r_addr[r_head], 2'b00};
    assign dm_be    = r_be[r_head];
    assign dm_din   = r_data[r_head];

    //------------------------------------------------------------------
    // Pointer and occupancy state
    //------------------------------------------------------------------
    // DEPTH is a power of two, so AW-bit pointers wrap by overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload write at the tail; a write during reset is harmless because
    // the tail pointer and count are cleared in the same edge.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= st_addr[31:2];
            r_be[r_tail]   <= st_be;
            r_data[r_tail] <= st_data;
        end
    end

    //------------------------------------------------------------------
    // Load lookup over every valid entry, head included
    //------------------------------------------------------------------
`ifdef SB_FWD_EN
    // Walk from oldest to youngest so the youngest store owning a lane
    // overwrites any older contribution to that lane.
    always_comb begin : fwd_lookup
        logic [AW-1:0] v_idx;
        ld_fwd_be   = 4'b0000;
        ld_fwd_data = 32'h0;
        v_idx       = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            v_idx = r_head + AW'(i);
            if ((CW'(i) < r_count) && (r_addr[v_idx] == ld_addr[31:2])) begin
                for (int l = 0; l < 4; l++) begin
                    if (r_be[v_idx][l]) begin
                        ld_fwd_be[l]         = 1'b1;
                        ld_fwd_data[l*8 +: 8] = r_data[v_idx][l*8 +: 8];
                    end
                end
            end
        end
    end

    assign ld_stall = 1'b0;
`else
    // Without forwarding, any valid entry on the same word blocks the load.
    always_comb begin : stall_lookup
        logic [AW-1:0] v_idx;
        ld_stall = 1'b0;
        v_idx    = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            v_idx = r_head + AW'(i);
            if ((CW'(i) < r_count) && (r_addr[v_idx] == ld_addr[31:2])) begin
                ld_stall = 1'b1;
            end
        end
    end

    assign ld_fwd_be   = 4'b0000;
    assign ld_fwd_data = 32'h0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by random traffic, all checked against a queue model.
// Latency: model outputs are compared at the falling edge; model state advances at the rising edge with the same inputs.
// Backpressure: the model refuses pushes when it holds DEPTH entries before the edge, regardless of a same-cycle drain.

module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk;
    logic          rst;
    logic          st_valid;
    logic          st_ready;
    logic [31:0]   st_addr;
    logic [3:0]    st_be;
    logic [31:0]   st_data;
    logic          dm_grant;
    logic          dm_wr;
    logic [31:0]   dm_addr;
    logic [3:0]    dm_be;
    logic [31:0]   dm_din;
    logic [31:0]   ld_addr;
    logic [3:0]    ld_fwd_be;
    logic [31:0]   ld_fwd_data;
    logic          ld_stall;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [29:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];

    store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_be       (st_be),
        .st_data     (st_data),
        .dm_grant    (dm_grant),
        .dm_wr       (dm_wr),
        .dm_addr     (dm_addr),
        .dm_be       (dm_be),
        .dm_din      (dm_din),
        .ld_addr     (ld_addr),
        .ld_fwd_be   (ld_fwd_be),
        .ld_fwd_data (ld_fwd_data),
        .ld_stall    (ld_stall),
        .full        (full),
        .empty       (empty),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d, input logic g, input logic [31:0] la);
        rst      = r;
        st_valid = v;
        st_addr  = a;
        st_be    = be;
        st_data  = d;
        dm_grant = g;
        ld_addr  = la;
    endtask

    // Wait to the falling edge and compare every output with the model.
    task automatic settle();
        int          sz;
        logic [3:0]  e_be;
        logic [31:0] e_d;
        logic [31:0] mask;
        logic        hit;
        @(negedge clk);
        sz   = q.size();
        e_be = 4'b0000;
        e_d  = 32'h0;
        hit  = 1'b0;
        for (int j = 0; j < sz; j++) begin
            if (q[j].a == ld_addr[31:2]) begin
                hit = 1'b1;
                for (int l = 0; l < 4; l++) begin
                    if (q[j].be[l]) begin
                        e_be[l]        = 1'b1;
                        e_d[l*8 +: 8]  = q[j].d[l*8 +: 8];
                    end
                end
            end
        end
        mask = {{8{e_be[3]}}, {8{e_be[2]}}, {8{e_be[1]}}, {8{e_be[0]}}};
        chk("empty",    32'(empty),    32'(sz == 0));
        chk("full",     32'(full),     32'(sz == DEPTH));
        chk("count",    32'(count),    32'(sz));
        chk("st_ready", 32'(st_ready), 32'(sz != DEPTH));
        chk("dm_wr",    32'(dm_wr),    32'((sz > 0) && dm_grant));
        if (sz > 0) begin
            chk("dm_addr", dm_addr,     {q[0].a, 2'b00});
            chk("dm_be",   32'(dm_be),  32'(q[0].be));
            chk("dm_din",  dm_din,      q[0].d);
        end
`ifdef SB_FWD_EN
        chk("ld_fwd_be",   32'(ld_fwd_be),     32'(e_be));
        chk("ld_fwd_data", ld_fwd_data & mask, e_d);
        chk("ld_stall",    32'(ld_stall),      32'h0);
`else
        chk("ld_fwd_be",   32'(ld_fwd_be),     32'h0);
        chk("ld_fwd_data", ld_fwd_data,        32'h0);
        chk("ld_stall",    32'(ld_stall),      32'(hit));
`endif
    endtask

    // Advance one rising edge and apply the same inputs to the model.
    task automatic tick();
        logic can_push;
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            can_push = (q.size() < DEPTH);
            if (dm_grant && q.size() > 0) begin
                void'(q.pop_front());
            end
            if (st_valid && can_push && st_be != 4'b0000) begin
                q.push_back('{a: st_addr[31:2], be: st_be, d: st_data});
            end
        end
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rl;

        // Reset
        drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
        settle();
        chk("rst_empty",    32'(empty),     32'h1);
        chk("rst_full",     32'(full),      32'h0);
        chk("rst_count",    32'(count),     32'h0);
        chk("rst_st_ready", 32'(st_ready),  32'h1);
        chk("rst_dm_wr",    32'(dm_wr),     32'h0);
        chk("rst_fwd_be",   32'(ld_fwd_be), 32'h0);
        chk("rst_ld_stall", 32'(ld_stall),  32'h0);
        tick();

        // Single store drains the cycle after it is pushed
        drive(1'b0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0);
        settle();
        chk("push_cycle_dm_wr", 32'(dm_wr), 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0);
        settle();
        chk("drain_dm_wr",   32'(dm_wr), 32'h1);
        chk("drain_dm_addr", dm_addr,    32'h100);
        chk("drain_dm_din",  dm_din,     32'hDEADBEEF);
        tick();
        settle();
        chk("drained_empty", 32'(empty), 32'h1);
        tick();

        // Fill with grant low, refuse a fifth store, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 32'h400 + 32'(i * 4), 4'hF, 32'hA0 + 32'(i), 1'b0, 32'h0);
            step();
        end
        drive(1'b0, 1'b1, 32'h500, 4'hF, 32'h55555555, 1'b0, 32'h0);
        settle();
        chk("fill_full",     32'(full),     32'h1);
        chk("fill_count",    32'(count),    32'h4);
        chk("fill_st_ready", 32'(st_ready), 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0);
            settle();
            chk("order_dm_din",  dm_din,  32'hA0 + 32'(i));
            chk("order_dm_addr", dm_addr, 32'h400 + 32'(i * 4));
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
        settle();
        chk("fifth_dropped_empty", 32'(empty), 32'h1);
        tick();

        // Full buffer with a drain in the same cycle still refuses the push
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 32'h600 + 32'(i * 4), 4'h3, 32'h11 * 32'(i + 1), 1'b0, 32'h0);
            step();
        end
        drive(1'b0, 1'b1, 32'h700, 4'hF, 32'h77777777, 1'b1, 32'h0);
        step();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
        settle();
        chk("full_pop_no_push_count", 32'(count), 32'h3);
        tick();

        // Reset with push and grant active discards everything
        drive(1'b1, 1'b1, 32'h800, 4'hF, 32'h12345678, 1'b1, 32'h0);
        step();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0);
        settle();
        chk("rst_prio_count", 32'(count), 32'h0);
        chk("rst_prio_empty", 32'(empty), 32'h1);
        chk("rst_prio_dm_wr", 32'(dm_wr), 32'h0);
        tick();

        // Zero byte-enable store is accepted but not enqueued
        drive(1'b0, 1'b1, 32'h900, 4'h0, 32'h99999999, 1'b0, 32'h0);
        settle();
        chk("be0_st_ready", 32'(st_ready), 32'h1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
        settle();
        chk("be0_empty", 32'(empty), 32'h1);
        tick();

        // Steady push+pop at count 2 across a pointer wrap
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 32'hA00 + 32'(i * 4), 4'hF, 32'hC0 + 32'(i), 1'b0, 32'h0);
            step();
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 32'hB00 + 32'(i * 4), 4'hF, 32'hD0 + 32'(i), 1'b1, 32'h0);
            settle();
            chk("pair_count", 32'(count), 32'h2);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
        settle();
        chk("pair_head_din", dm_din, 32'hD4);
        tick();
        drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
        step();

        // Two partial stores to one word: lookup by word address
        drive(1'b0, 1'b1, 32'h200, 4'b0001, 32'h000000AA, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b1, 32'h200, 4'b0100, 32'h00CC0000, 1'b0, 32'h0);
        step();
`ifdef SB_FWD_EN
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h202);
        settle();
        chk("fwd_be",   32'(ld_fwd_be),                 32'h5);
        chk("fwd_data", ld_fwd_data & 32'h00FF00FF,     32'h00CC00AA);
        tick();
`else
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h200);
        settle();
        chk("stall_hit", 32'(ld_stall), 32'h1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h204);
        settle();
        chk("stall_miss", 32'(ld_stall), 32'h0);
        tick();
`endif

        // Random traffic on a small address pool so loads hit often
        for (int n = 0; n < 600; n++) begin
            ra = 32'h200 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            rl = 32'h200 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3));
            drive(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), ra,
                  4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 2) == 0), rl);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 SHALL provide parameter CW, default 3, occupancy counter width (log2(DEPTH)+1).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port st_valid  input  1  MEM stage presents a store.
REQ-007 SHALL have port st_ready  output  1  buffer accepts a store this cycle.
REQ-008 SHALL have port st_addr  input  32  store byte address.
REQ-009 SHALL have port st_be  input  4  byte enables from the store byte-enable stage.
REQ-010 SHALL have port st_data  input  32  lane-replicated store data.
REQ-011 SHALL have port dm_grant  input  1  DM write port free this cycle.
REQ-012 SHALL have port dm_wr, dm_addr, dm_be, dm_din  output  1/32/4/32  DM write port drive.
REQ-013 SHALL have port ld_addr  input  32  load address for forwarding lookup.
REQ-014 SHALL have port ld_fwd_be  output  4  lanes supplied by buffer.
REQ-015 SHALL have port ld_fwd_data  output  32  forwarded lane data.
REQ-016 SHALL have port ld_stall  output  1  load must wait.
REQ-017 SHALL have ports full, empty  output  1 each; count  output  CW  occupancy.

Function
REQ-018 SHALL hold entries {addr[31:2], be, data} in a circular FIFO with head/tail pointers wrapping modulo DEPTH.
REQ-019 SHALL push when st_valid && st_ready; st_ready = !full, derived from registered state only.
REQ-020 SHALL refuse a push when full even if a pop occurs the same cycle.
REQ-021 SHALL drain combinationally: dm_wr = !empty && dm_grant; dm_addr = {head.addr,2'b00}; dm_be/dm_din = head entry.
REQ-022 SHALL pop the head on the same rising edge that dm_wr is high (one store per cycle).
REQ-023 SHALL keep count unchanged on simultaneous push and pop; +1 on push only; -1 on pop only.
REQ-024 SHALL make a pushed entry drainable/forwardable no earlier than the cycle after push (latency 1, no bypass).
REQ-025 SHALL drop a store with st_be == 0 (accept, not enqueued).
REQ-026 SHALL compare ld_addr[31:2] to every valid entry, including the head being drained this cycle.
REQ-027 SHALL keep all outputs pure functions of registered state plus dm_grant/ld_addr.

Reset
REQ-028 SHALL on rst clear head, tail and count; entry payloads need not clear.
REQ-029 SHALL drive after reset: empty=1, full=0, count=0, st_ready=1, dm_wr=0, ld_fwd_be=0, ld_stall=0.
REQ-030 SHALL give rst priority over simultaneous push/pop; stores in flight are discarded.

Configuration
REQ-031 SHALL use macro SB_FWD_EN to select store-to-load forwarding.
REQ-032 With SB_FWD_EN: per lane, ld_fwd_be/ld_fwd_data from youngest matching entry with that BE bit; ld_stall=0.
REQ-033 Without SB_FWD_EN: ld_fwd_be=0, ld_fwd_data=0; ld_stall=1 when any valid entry matches ld_addr[31:2].

Verification
REQ-034 Reset then push {0x100,4'b1111,0xDEADBEEF}, dm_grant=1 -> next cycle dm_wr=1, dm_addr=0x100, dm_din=0xDEADBEEF; then empty=1.
REQ-035 dm_grant=0, push 4 stores -> full=1, count=4, st_ready=0; 5th st_valid ignored; grant=1 drains 4 in order over 4 cycles.
REQ-036 Count=2, push and grant same cycle -> count stays 2; pointers wrap after 5 further push/pop pairs without data loss.
REQ-037 SB_FWD_EN: buffer {0x200,0001,0x000000AA} then {0x200,0100,0x00CC0000}; ld_addr=0x202 -> ld_fwd_be=0101, ld_fwd_data=0x00CC00AA.
REQ-038 SB_FWD_EN off: same contents, ld_addr=0x200 -> ld_stall=1; ld_addr=0x204 -> ld_stall=0.
REQ-039 Count=3, assert rst with st_valid=1 and dm_grant=1 -> next cycle count=0, empty=1, dm_wr=0.
